// File: rtl/sort_stream_loader_pkg.sv
// Shared types and constants for the sort stream loader: FSM encoding,
// element width default and the pad value used for short vectors.
package sort_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    OUT    = 2'd3
  } state_e;

  localparam int FIX_POINT_WIDTH_DEF = 16;

  // Signed minimum of a w-bit two's-complement value, so pads never win a max.
  function automatic logic [63:0] pad_of(input int w);
    return 64'd1 << (w - 1);
  endfunction

  localparam logic [FIX_POINT_WIDTH_DEF-1:0] PAD =
    FIX_POINT_WIDTH_DEF'(pad_of(FIX_POINT_WIDTH_DEF));

endpackage

// File: rtl/sort_stream_loader_if.sv
// Bundle of the upstream element stream, sorter launch/finish and result stream.
interface sort_stream_loader_if
  import sort_pkg::*;
#(
  parameter int FIX_POINT_WIDTH = FIX_POINT_WIDTH_DEF,
  parameter int DATA_NUM        = 8
);
  localparam int LEN_W = $clog2(DATA_NUM + 1);

  logic                                s_valid;
  logic [FIX_POINT_WIDTH-1:0]          s_data;
  logic                                s_last;
  logic                                s_ready;
  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] sort_data;
  logic                                sort_en;
  logic                                sort_finish;
  logic [FIX_POINT_WIDTH-1:0]          sort_max;
  logic                                m_valid;
  logic                                m_ready;
  logic [FIX_POINT_WIDTH-1:0]          m_data;
  logic [LEN_W-1:0]                    m_len;

  // Loader side.
  modport slave (
    input  s_valid, s_data, s_last, sort_finish, sort_max, m_ready,
    output s_ready, sort_data, sort_en, m_valid, m_data, m_len
  );

  // Environment side: upstream source, sorter and downstream sink.
  modport master (
    output s_valid, s_data, s_last, sort_finish, sort_max, m_ready,
    input  s_ready, sort_data, sort_en, m_valid, m_data, m_len
  );

endinterface

// File: rtl/sort_stream_loader.sv
// Collects a stream of elements into a padded vector, launches the sorter,
// waits for its completion edge and hands the captured maximum downstream.
module sort_stream_loader
  import sort_pkg::*;
#(
  parameter int FIX_POINT_WIDTH = FIX_POINT_WIDTH_DEF,
  parameter int DATA_NUM        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sort_stream_loader_if.slave  bus
);
  localparam int W     = FIX_POINT_WIDTH;
  localparam int LEN_W = $clog2(DATA_NUM + 1);
  localparam logic [W-1:0] PAD_LANE = W'(pad_of(W));

  typedef logic [DATA_NUM-1:0][W-1:0] lanes_t;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] m_len_q, m_len_d;
  lanes_t           lanes_q, lanes_d;
  logic [W-1:0]     m_data_q, m_data_d;
  logic             finish_q, finish_d;
  logic             accept, close, fin_rise;

  assign accept   = bus.s_valid && (state_q == FILL);
  // A last flag on the final lane coincides with the full-count close.
  assign close    = accept && (bus.s_last || (cnt_q == LEN_W'(DATA_NUM - 1)));
  // Only a fresh rising edge seen in WAIT counts; a stale high level does not.
  assign fin_rise = (state_q == WAIT) && bus.sort_finish && !finish_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      lanes_q  <= '0;
      m_data_q <= '0;
      m_len_q  <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lanes_q  <= lanes_d;
      m_data_q <= m_data_d;
      m_len_q  <= m_len_d;
      finish_q <= finish_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (close) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (fin_rise) state_d = OUT;
      OUT:     if (bus.m_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    lanes_d  = lanes_q;
    m_len_d  = m_len_q;
    m_data_d = m_data_q;
    finish_d = bus.sort_finish;
    if (accept) begin
      for (int k = 0; k < DATA_NUM; k++) begin
        if (LEN_W'(k) == cnt_q)                lanes_d[k] = bus.s_data;
        else if (close && (LEN_W'(k) > cnt_q)) lanes_d[k] = PAD_LANE;
      end
      cnt_d = cnt_q + 1'b1;
      if (close) m_len_d = cnt_q + 1'b1;
    end
    if (fin_rise) m_data_d = bus.sort_max;
    if ((state_q == OUT) && bus.m_ready) cnt_d = '0;
  end

  always_comb begin
    bus.s_ready = (state_q == FILL);
    bus.sort_en = (state_q == LAUNCH);
    bus.m_valid = (state_q == OUT);
  end

  assign bus.sort_data = lanes_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_len     = m_len_q;

endmodule

// File: doc/sort_stream_loader.md
SORT_STREAM_LOADER -- requirements
Module: sort_stream_loader

Interface
REQ-001 SHALL have parameter FIX_POINT_WIDTH, default 16, element width in bits (signed two's-complement).
REQ-002 SHALL have parameter DATA_NUM, default 8, elements per sort vector; even, >=2.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port s_valid, input, 1, upstream element valid.
REQ-006 SHALL have port s_data, input, FIX_POINT_WIDTH, upstream element.
REQ-007 SHALL have port s_last, input, 1, the element closes the current vector.
REQ-008 SHALL have port s_ready, output, 1, element accepted when s_valid&s_ready.
REQ-009 SHALL have port sort_data, output, DATA_NUM*FIX_POINT_WIDTH, packed vector to the sorter; lane k at bits [(k+1)*W-1:k*W].
REQ-010 SHALL have port sort_en, output, 1, sort launch strobe.
REQ-011 SHALL have port sort_finish, input, 1, sorter completion.
REQ-012 SHALL have port sort_max, input, FIX_POINT_WIDTH, sorter maximum result.
REQ-013 SHALL have port m_valid, output, 1, result valid.
REQ-014 SHALL have port m_ready, input, 1, downstream accepts result.
REQ-015 SHALL have port m_data, output, FIX_POINT_WIDTH, captured maximum.
REQ-016 SHALL have port m_len, output, clog2(DATA_NUM+1), count of real (non-pad) elements in the vector.

Function
REQ-017 SHALL implement FSM states FILL, LAUNCH, WAIT, OUT.
REQ-018 SHALL assert s_ready only in FILL; all other states back-pressure upstream.
REQ-019 SHALL write the element accepted in FILL to lane cnt and increment cnt; the first element of a vector goes to lane 0.
REQ-020 SHALL close the vector when an element is accepted with s_last=1 or with cnt=DATA_NUM-1, then move to LAUNCH.
REQ-021 SHALL, on the closing edge, write PAD = signed minimum (0x8000 at W=16) to every lane above the closing lane, with no extra cycles.
REQ-022 SHALL ignore s_last when it is set on the DATA_NUM-th element (close once, no pad).
REQ-023 SHALL register m_len = cnt+1 at close.
REQ-024 SHALL hold sort_en=1 for exactly the single LAUNCH cycle, then enter WAIT.
REQ-025 SHALL hold sort_data stable from LAUNCH until m_valid handshake completes.
REQ-026 SHALL register sort_finish every cycle (finish_d) and detect completion as sort_finish & ~finish_d while in WAIT only.
REQ-027 SHALL ignore sort_finish edges outside WAIT; a level held high from a previous run SHALL NOT complete WAIT.
REQ-028 SHALL, on detected completion, latch sort_max into m_data and enter OUT; m_valid rises the cycle after the edge is sampled.
REQ-029 SHALL hold m_valid, m_data, m_len stable in OUT until m_valid&m_ready, then clear m_valid, reset cnt to 0, and enter FILL.
REQ-030 SHALL have minimum throughput of one vector per DATA_NUM+3+sorter-latency cycles; FILL SHALL NOT overlap OUT.

Reset
REQ-031 SHALL, when rst=0 at a clock edge, set state=FILL, cnt=0, sort_data=0, sort_en=0, m_valid=0, m_data=0, m_len=0, finish_d=0, in any state including mid-fill or WAIT.
REQ-032 SHALL discard a partially filled or in-flight vector on reset; no result is emitted for it.

Structure
REQ-033 SHALL place the FSM state encoding, the PAD constant, and the FIX_POINT_WIDTH default in shared package sort_pkg.
REQ-034 SHALL be one flat module; no sub-module is required (lane write-enable decode inline).

Verification (W=16, DATA_NUM=8, sorter model with 20-cycle latency)
REQ-035 SHALL check full vector: 8 elements 1..8 back-to-back with no s_last -> one sort_en pulse, lanes 0..7 = 1..8, m_data=8, m_len=8.
REQ-036 SHALL check short vector: 3, -5, 2 with s_last on the third -> lanes 3..7 = 0x8000, m_data=3, m_len=3; all-negative -7,-9 with s_last -> m_data=-7.
REQ-037 SHALL check back-pressure: m_ready held 0 for 10 cycles -> m_valid/m_data stable, s_ready=0 throughout; release -> s_ready=1 the next cycle.
REQ-038 SHALL check stale finish: sort_finish held 1 entering WAIT, dropped, raised 5 cycles later -> capture only on the second rise.
REQ-039 SHALL check reset mid-fill (after 4 elements) and mid-WAIT -> all outputs 0, s_ready=1 the cycle after rst=1, next vector correct.
REQ-040 SHALL check single element 0x7FFF with s_last, upstream s_valid toggled randomly -> m_data=0x7FFF, m_len=1.
